// File: rtl/counter_cmd_seq_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the counter command sequencer: default data width,
// command opcodes and the sequencer FSM state encoding.
// -----------------------------------------------------------------------------
package counter_pkg;

  localparam int WIDTH = 8;

  // Command opcodes carried on cmd_op
  localparam logic [1:0] OP_CLR  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [1:0] OP_DOWN = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_EXEC_CLR  = 2'b01,
    ST_EXEC_LOAD = 2'b10,
    ST_RUN       = 2'b11
  } state_t;

endpackage

// File: rtl/counter_cmd_seq_if.sv
// -----------------------------------------------------------------------------
// counter_cmd_seq_if
// Command handshake between a command producer and the sequencer.
//   cmd_valid  producer -> sequencer  command present
//   cmd_ready  sequencer -> producer  command FIFO can accept
//   cmd_op     producer -> sequencer  00 CLR, 01 LOAD, 10 UP, 11 DOWN
//   cmd_data   producer -> sequencer  LOAD value or step count
// -----------------------------------------------------------------------------
interface counter_cmd_seq_if #(
  parameter int WIDTH = counter_pkg::WIDTH
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/counter_cmd_seq_cmd_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
// Synchronous FIFO holding {op, data} command words.
//   clk    in   clock
//   clear  in   synchronous flush, active-high
//   push   in   write wdata (ignored when full)
//   wdata  in   command word
//   pop    in   drop head entry (ignored when empty)
//   full   out  no free entry
//   empty  out  no valid entry
//   head   out  oldest entry, valid when !empty
// -----------------------------------------------------------------------------
module cmd_fifo #(
  parameter int DW    = 10,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic [DW-1:0] mem_r [DEPTH];
  logic          full_s;
  logic          empty_s;

  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full    = full_s;
  assign empty   = empty_s;
  assign head    = mem_r[rd_ptr_r[AW-1:0]];

  // Read/write pointer update with synchronous flush
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push && !full_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop && !empty_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (push && !full_s && !clear) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/counter_cmd_seq.sv
// -----------------------------------------------------------------------------
// counter_cmd_seq
// Command sequencer in front of an 8-bit up/down counter that has no enable.
// Commands are queued in a FIFO and replayed onto the counter control pins;
// when idle the counter's own output is reloaded so it holds its value.
//   clk          in   clock
//   clear        in   synchronous reset, active-high (also clears the counter)
//   cmd          if   command handshake (slave side)
//   cnt_q        in   counter output fed back
//   ctr_in       out  counter data input
//   ctr_load     out  counter load
//   ctr_up_down  out  counter direction (1 = up)
//   ctr_clear_n  out  counter clear, active-low
//   busy         out  executing or commands pending
//   done         out  one-cycle pulse after a command finishes
// -----------------------------------------------------------------------------
module counter_cmd_seq #(
  parameter int WIDTH      = counter_pkg::WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  counter_cmd_seq_if.slave cmd,
  input  logic [WIDTH-1:0] cnt_q,
  output logic [WIDTH-1:0] ctr_in,
  output logic             ctr_load,
  output logic             ctr_up_down,
  output logic             ctr_clear_n,
  output logic             busy,
  output logic             done
);
  import counter_pkg::*;

  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] STEP_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   data_r;
  logic [WIDTH-1:0]   remaining_r;
  logic               dir_r;
  logic               done_r;
  logic               done_nxt_s;

  logic               cmd_ready_s;
  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic               empty_s;
  logic [WIDTH+1:0]   head_s;
  logic [1:0]         head_op_s;
  logic [WIDTH-1:0]   head_data_s;

  // Ready is withheld during clear so nothing is queued while flushing.
  assign cmd_ready_s   = !full_s && !clear;
  assign cmd.cmd_ready = cmd_ready_s;
  assign push_s        = cmd.cmd_valid && cmd_ready_s;
  assign head_op_s     = head_s[WIDTH+1:WIDTH];
  assign head_data_s   = head_s[WIDTH-1:0];

  cmd_fifo #(
    .DW    (WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clear (clear),
    .push  (push_s),
    .wdata ({cmd.cmd_op, cmd.cmd_data}),
    .pop   (pop_s),
    .full  (full_s),
    .empty (empty_s),
    .head  (head_s)
  );

  // Next-state, pop and done-pulse decision
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    done_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s = 1'b1;
          case (head_op_s)
            OP_CLR:  state_nxt_s = ST_EXEC_CLR;
            OP_LOAD: state_nxt_s = ST_EXEC_LOAD;
            OP_UP, OP_DOWN: begin
              // A zero step count finishes straight from IDLE.
              if (head_data_s == ZERO_W) begin
                state_nxt_s = ST_IDLE;
                done_nxt_s  = 1'b1;
              end else begin
                state_nxt_s = ST_RUN;
              end
            end
            default: state_nxt_s = ST_IDLE;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC_CLR, ST_EXEC_LOAD: begin
        state_nxt_s = ST_IDLE;
        done_nxt_s  = 1'b1;
      end
      ST_RUN: begin
        // Exit on the last step so exactly n steps reach the counter.
        if (remaining_r == STEP_ONE) begin
          state_nxt_s = ST_IDLE;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, captured head command and step counter
  always_ff @(posedge clk) begin
    if (clear) begin
      state_r     <= ST_IDLE;
      data_r      <= ZERO_W;
      remaining_r <= ZERO_W;
      dir_r       <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= done_nxt_s;
      if (pop_s) begin
        data_r      <= head_data_s;
        remaining_r <= head_data_s;
        dir_r       <= (head_op_s == OP_UP);
      end else if (state_r == ST_RUN) begin
        remaining_r <= remaining_r - STEP_ONE;
      end
    end
  end

  // Counter pin drive; clear forces the counter into its own clear as well
  always_comb begin
    ctr_in      = ZERO_W;
    ctr_load    = 1'b0;
    ctr_up_down = 1'b0;
    ctr_clear_n = 1'b0;
    if (clear) begin
      ctr_clear_n = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ctr_load    = 1'b1;
          ctr_in      = cnt_q;
          ctr_clear_n = 1'b1;
        end
        ST_EXEC_CLR: begin
          ctr_clear_n = 1'b0;
        end
        ST_EXEC_LOAD: begin
          ctr_load    = 1'b1;
          ctr_in      = data_r;
          ctr_clear_n = 1'b1;
        end
        ST_RUN: begin
          ctr_up_down = dir_r;
          ctr_clear_n = 1'b1;
        end
        default: begin
          ctr_clear_n = 1'b0;
        end
      endcase
    end
  end

  assign busy = !clear && ((state_r != ST_IDLE) || !empty_s);
  assign done = done_r && !clear;

endmodule

// File: tb/tb_counter_cmd_seq.sv
// -----------------------------------------------------------------------------
// tb_counter_cmd_seq
// Directed bench: sequencer plus a behavioural model of the 8-bit counter.
// -----------------------------------------------------------------------------
module tb_counter_cmd_seq;
  import counter_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clear;
  logic [W-1:0] cnt_q;
  logic [W-1:0] ctr_in;
  logic         ctr_load;
  logic         ctr_up_down;
  logic         ctr_clear_n;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  int done_total = 0;
  int run_total = 0;

  counter_cmd_seq_if #(.WIDTH(W)) cmd_if ();

  counter_cmd_seq #(.WIDTH(W), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .clear       (clear),
    .cmd         (cmd_if),
    .cnt_q       (cnt_q),
    .ctr_in      (ctr_in),
    .ctr_load    (ctr_load),
    .ctr_up_down (ctr_up_down),
    .ctr_clear_n (ctr_clear_n),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Counter being sequenced: sync active-low clear, load, else step
  always @(posedge clk) begin
    if (!ctr_clear_n)     cnt_q <= 8'h00;
    else if (ctr_load)    cnt_q <= ctr_in;
    else if (ctr_up_down) cnt_q <= cnt_q + 8'h01;
    else                  cnt_q <= cnt_q - 8'h01;
  end

  // Running totals of done pulses and counting cycles
  always @(negedge clk) begin
    if (done === 1'b1) done_total = done_total + 1;
    if (clear === 1'b0 && ctr_load === 1'b0 && ctr_clear_n === 1'b1) run_total = run_total + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [1:0] op, input logic [W-1:0] d, output int waited);
    waited = 0;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = d;
    while (cmd_if.cmd_ready !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 2000) begin
      checks++; errors++;
      $display("FAIL push_timeout: cmd_ready stayed %b, required 1", cmd_if.cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL %s_idle_timeout: busy=%b, required 0", name, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_data  = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_if.cmd_ready, busy, done, ctr_clear_n, ctr_load, ctr_up_down} !== 6'b000000) begin
      errors++;
      $display("FAIL reset_ctrl: ready,busy,done,clr_n,load,ud=%b required 000000",
               {cmd_if.cmd_ready, busy, done, ctr_clear_n, ctr_load, ctr_up_down});
    end
    checks++;
    if (ctr_in !== 8'h00) begin errors++; $display("FAIL reset_ctr_in: got %h required 00", ctr_in); end
    checks++;
    if (cnt_q !== 8'h00) begin errors++; $display("FAIL reset_cnt: got %h required 00", cnt_q); end
    clear = 1'b0;
    #1;
    checks++;
    if ({cmd_if.cmd_ready, busy, done, ctr_clear_n, ctr_load} !== 5'b10011) begin
      errors++;
      $display("FAIL idle_ctrl: ready,busy,done,clr_n,load=%b required 10011",
               {cmd_if.cmd_ready, busy, done, ctr_clear_n, ctr_load});
    end
    checks++;
    if (ctr_in !== 8'h00) begin errors++; $display("FAIL idle_passthru: got %h required 00", ctr_in); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (cnt_q !== 8'h00) begin errors++; $display("FAIL idle_hold[%0d]: got %h required 00", i, cnt_q); end
    end
  endtask

  task automatic test_load_up();
    int d0 = done_total;
    int r0 = run_total;
    int w;
    push(OP_LOAD, 8'h10, w);
    push(OP_UP, 8'd5, w);
    @(negedge clk);
    checks++;
    if (ctr_load !== 1'b1 || ctr_in !== 8'h10) begin
      errors++; $display("FAIL exec_load: load=%b in=%h required 1/10", ctr_load, ctr_in);
    end
    @(negedge clk);
    checks++;
    if (cnt_q !== 8'h10 || done !== 1'b1) begin
      errors++; $display("FAIL after_load: cnt=%h done=%b required 10/1", cnt_q, done);
    end
    wait_idle("load_up");
    checks++;
    if (cnt_q !== 8'h15) begin errors++; $display("FAIL up5_cnt: got %h required 15", cnt_q); end
    checks++;
    if (run_total - r0 !== 5) begin errors++; $display("FAIL up5_runs: got %0d required 5", run_total - r0); end
    checks++;
    if (done_total - d0 !== 2) begin errors++; $display("FAIL up5_dones: got %0d required 2", done_total - d0); end
    repeat (3) @(negedge clk);
    checks++;
    if (cnt_q !== 8'h15) begin errors++; $display("FAIL up5_hold: got %h required 15", cnt_q); end
  endtask

  task automatic test_wrap();
    int w;
    push(OP_LOAD, 8'hFE, w);
    push(OP_UP, 8'd3, w);
    wait_idle("wrap_up");
    checks++;
    if (cnt_q !== 8'h01) begin errors++; $display("FAIL wrap_up: got %h required 01", cnt_q); end
    push(OP_DOWN, 8'd2, w);
    wait_idle("wrap_down");
    checks++;
    if (cnt_q !== 8'hFF) begin errors++; $display("FAIL wrap_down: got %h required FF", cnt_q); end
  endtask

  task automatic test_fifo_full();
    int d0 = done_total;
    int r0 = run_total;
    int w;
    push(OP_UP, 8'd200, w);
    push(OP_LOAD, 8'h20, w);
    push(OP_UP, 8'd3, w);
    push(OP_DOWN, 8'd1, w);
    push(OP_LOAD, 8'h40, w);
    @(negedge clk);
    checks++;
    if (cmd_if.cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL fifo_full: ready=%b busy=%b required 0/1", cmd_if.cmd_ready, busy);
    end
    push(OP_UP, 8'd2, w);
    checks++;
    if (w < 150) begin errors++; $display("FAIL fifo_hold: 5th waited %0d cycles, required >=150", w); end
    wait_idle("fifo");
    checks++;
    if (cnt_q !== 8'h42) begin errors++; $display("FAIL fifo_order_cnt: got %h required 42", cnt_q); end
    checks++;
    if (done_total - d0 !== 6) begin errors++; $display("FAIL fifo_dones: got %0d required 6", done_total - d0); end
    checks++;
    if (run_total - r0 !== 206) begin errors++; $display("FAIL fifo_runs: got %0d required 206", run_total - r0); end
  endtask

  task automatic test_up_zero_clr();
    int r0 = run_total;
    int w;
    push(OP_UP, 8'd0, w);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL up0_pending: busy=%b done=%b required 1/0", busy, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cnt_q !== 8'h42) begin
      errors++; $display("FAIL up0_done: done=%b busy=%b cnt=%h required 1/0/42", done, busy, cnt_q);
    end
    checks++;
    if (run_total - r0 !== 0) begin errors++; $display("FAIL up0_runs: got %0d required 0", run_total - r0); end
    push(OP_CLR, 8'h00, w);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ctr_clear_n !== 1'b0 || cnt_q !== 8'h42) begin
      errors++; $display("FAIL clr_exec: clr_n=%b cnt=%h required 0/42", ctr_clear_n, cnt_q);
    end
    @(negedge clk);
    checks++;
    if (cnt_q !== 8'h00 || done !== 1'b1) begin
      errors++; $display("FAIL clr_result: cnt=%h done=%b required 00/1", cnt_q, done);
    end
  endtask

  task automatic test_clear_mid_run();
    int d0;
    int n = 0;
    int w;
    push(OP_LOAD, 8'h50, w);
    wait_idle("pre_clear");
    d0 = done_total;
    push(OP_UP, 8'd100, w);
    push(OP_LOAD, 8'h99, w);
    @(negedge clk);
    while (cnt_q !== 8'h78 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 500) begin errors++; $display("FAIL reach_step40: cnt=%h required 78", cnt_q); end
    clear = 1'b1;
    @(negedge clk);
    checks++;
    if (cnt_q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_clear: cnt=%h busy=%b done=%b required 00/0/0", cnt_q, busy, done);
    end
    clear = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL post_clear: busy=%b ready=%b required 0/1", busy, cmd_if.cmd_ready);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (cnt_q !== 8'h00) begin errors++; $display("FAIL flushed: cnt=%h required 00", cnt_q); end
    checks++;
    if (done_total - d0 !== 0) begin errors++; $display("FAIL abort_done: got %0d pulses required 0", done_total - d0); end
  endtask

  initial begin
    test_reset();
    test_load_up();
    test_wrap();
    test_fifo_full();
    test_up_zero_clr();
    test_clear_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
